// File: rtl/pe_stream_wrapper.sv
// Streaming wrapper around a free-running, fixed-latency PE core. Credit-gated input, a valid
// shift register that tracks beats inside the core, and an output FIFO that the credits keep from overflowing.
module pe_stream_wrapper #(
    parameter int DATA_W    = 128,
    parameter int LATENCY   = 20,
    parameter int OUT_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic [DATA_W-1:0]              core_in,
    input  logic [DATA_W-1:0]              core_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           done,
    output logic [$clog2(OUT_DEPTH+1)-1:0] inflight,
    output logic [$clog2(OUT_DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [LATENCY-1:0] vld_sr;
    logic [DATA_W-1:0]  mem [OUT_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW:0]        credit_used;
    logic               accept;
    logic               capture;
    logic               pop;

    // Pointers wrap explicitly so OUT_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every accepted beat holds one credit until it leaves the FIFO.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready    = credit_used < (CW+1)'(OUT_DEPTH);
    assign accept      = in_valid & in_ready;
    assign capture     = vld_sr[LATENCY-1];
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid & out_ready;
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    // Stage: operand register into the core plus the in-flight valid tracker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_in <= '0;
            vld_sr  <= '0;
        end else begin
            if (accept) begin
                core_in <= in_data;
            end
            vld_sr[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                vld_sr[k] <= vld_sr[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({accept, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Stage: result capture into the output FIFO
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= core_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(capture && (fifo_count == CW'(OUT_DEPTH))));

endmodule

// File: tb/tb_pe_stream_wrapper.sv
// Scoreboard bench for pe_stream_wrapper: directed tests on a 20/32 build and
// randomized traffic on a 1/3 build, with an external PE core model on each.
module tb_pe_stream_wrapper;
    localparam int DW  = 128;
    localparam int LA  = 20;
    localparam int DA  = 32;
    localparam int LB  = 1;
    localparam int DB  = 3;
    localparam int CWA = $clog2(DA + 1);
    localparam int CWB = $clog2(DB + 1);
    localparam logic [DW-1:0] MAGIC = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, done_a;
    logic [DW-1:0]  in_data_a, core_in_a, core_out_a, out_data_a;
    logic [CWA-1:0] inflight_a, fifo_count_a;
    logic           reset_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, done_b;
    logic [DW-1:0]  in_data_b, core_in_b, core_out_b, out_data_b;
    logic [CWB-1:0] inflight_b, fifo_count_b;

    pe_stream_wrapper #(.DATA_W(DW), .LATENCY(LA), .OUT_DEPTH(DA)) dut_a (
        .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .core_in(core_in_a), .core_out(core_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .done(done_a), .inflight(inflight_a), .fifo_count(fifo_count_a));

    pe_stream_wrapper #(.DATA_W(DW), .LATENCY(LB), .OUT_DEPTH(DB)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .core_in(core_in_b), .core_out(core_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .done(done_b), .inflight(inflight_b), .fifo_count(fifo_count_b));

    // The PE function itself; the reference result of any beat is just pe_f(beat).
    function automatic logic [DW-1:0] pe_f(input logic [DW-1:0] x);
        return {x[DW-2:0], x[DW-1]} ^ MAGIC;
    endfunction

    // External core models: the result for core_in must be on core_out LATENCY edges later.
    logic [DW-1:0] pipe_a [LA-1];
    always @(posedge clk) begin
        pipe_a[0] <= core_in_a;
        for (int k = 1; k < LA - 1; k++) pipe_a[k] <= pipe_a[k-1];
    end
    assign core_out_a = pe_f(pipe_a[LA-2]);
    assign core_out_b = pe_f(core_in_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];
    int done_cyc_a [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: a pop happens at the next edge whenever out_valid & out_ready are seen here.
    always @(negedge clk) begin
        if (!reset_a) begin
            if (done_a) done_cyc_a.push_back(cyc);
            if (out_valid_a && out_ready_a) begin
                if (exp_a.size() == 0) chki("pop_a_unexpected", 1, 0);
                else chk("out_data_a", out_data_a, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_b) begin
            chki("credit_b_le_depth", int'((int'(inflight_b) + int'(fifo_count_b)) <= DB), 1);
            if (out_valid_b && out_ready_b) begin
                if (exp_b.size() == 0) chki("pop_b_unexpected", 1, 0);
                else chk("out_data_b", out_data_b, exp_b.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; they take effect at the next edge, numbered edge_n.
    task automatic drive_a(input logic iv, input logic [DW-1:0] d, input logic ordy,
                           output logic acc, output int edge_n);
        @(posedge clk);
        #1;
        in_valid_a  = iv;
        in_data_a   = d;
        out_ready_a = ordy;
        acc         = iv && in_ready_a;
        edge_n      = cyc + 1;
        if (acc) exp_a.push_back(pe_f(d));
    endtask

    task automatic drive_b(input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        in_valid_b  = iv;
        in_data_b   = d;
        out_ready_b = ordy;
        if (iv && in_ready_b) exp_b.push_back(pe_f(d));
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_a();
        logic acc;
        int   e, e0, n_acc, last_i;
        // single beat latency
        drive_a(1'b1, {16{8'hA5}}, 1'b1, acc, e0);
        chki("t1_accept", int'(acc), 1);
        drive_a(1'b0, '0, 1'b1, acc, e);
        wait_cyc(e0 + LA - 1);
        chki("t1_out_valid_early", int'(out_valid_a), 0);
        chki("t1_done_early", int'(done_a), 0);
        wait_cyc(e0 + LA);
        chki("t1_out_valid", int'(out_valid_a), 1);
        chki("t1_done", int'(done_a), 1);
        chk("t1_out_data", out_data_a, pe_f({16{8'hA5}}));
        chki("t1_inflight", int'(inflight_a), 0);
        wait_cyc(e0 + LA + 1);
        chki("t1_done_pulse_end", int'(done_a), 0);
        chki("t1_fifo_empty", int'(fifo_count_a), 0);

        // back-to-back stream
        done_cyc_a.delete();
        for (int i = 0; i < 32; i++) begin
            drive_a(1'b1, DW'(i), 1'b1, acc, e);
            if (i == 0) e0 = e;
            chki("t2_in_ready_held", int'(acc), 1);
        end
        drive_a(1'b0, '0, 1'b1, acc, e);
        wait_cyc(e0 + LA + 34);
        chki("t2_done_count", done_cyc_a.size(), 32);
        if (done_cyc_a.size() == 32) begin
            chki("t2_first_done", done_cyc_a[0], e0 + LA);
            chki("t2_last_done", done_cyc_a[31], e0 + LA + 31);
        end
        chki("t2_scoreboard_empty", exp_a.size(), 0);

        // stalled consumer fills all credits
        n_acc = 0;
        last_i = -1;
        for (int i = 0; i < 60; i++) begin
            drive_a(1'b1, rnd(), 1'b0, acc, e);
            if (acc) begin
                n_acc++;
                last_i = i;
            end
        end
        chki("t3_accepts", n_acc, DA);
        chki("t3_last_accept_idx", last_i, DA - 1);
        chki("t3_in_ready_low", int'(in_ready_a), 0);
        chki("t3_fifo_full", int'(fifo_count_a), DA);
        chki("t3_inflight", int'(inflight_a), 0);

        // a single pop frees exactly one credit
        drive_a(1'b1, rnd(), 1'b1, acc, e);
        chki("t4_no_accept_while_full", int'(acc), 0);
        drive_a(1'b1, rnd(), 1'b0, acc, e);
        chki("t4_accept_after_pop", int'(acc), 1);
        n_acc = 0;
        for (int i = 0; i < LA + 5; i++) begin
            drive_a(1'b1, rnd(), 1'b0, acc, e);
            if (acc) n_acc++;
        end
        chki("t4_no_extra_accepts", n_acc, 0);
        chki("t4_fifo_full_again", int'(fifo_count_a), DA);
        for (int i = 0; i < 80 && exp_a.size() != 0; i++) drive_a(1'b0, '0, 1'b1, acc, e);
        chki("t4_drained", exp_a.size(), 0);
        chki("t4_fifo_count_zero", int'(fifo_count_a), 0);

        // reset mid-flight discards everything
        done_cyc_a.delete();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, rnd(), 1'b1, acc, e);
            if (i == 0) e0 = e;
        end
        drive_a(1'b0, '0, 1'b1, acc, e);
        wait_cyc(e0 + 10);
        chki("t5_inflight_before_reset", int'(inflight_a), 3);
        reset_a = 1'b1;
        exp_a.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        #1;
        chk("t5_core_in", core_in_a, '0);
        chki("t5_out_valid", int'(out_valid_a), 0);
        chk("t5_out_data", out_data_a, '0);
        chki("t5_done", int'(done_a), 0);
        chki("t5_inflight", int'(inflight_a), 0);
        chki("t5_fifo_count", int'(fifo_count_a), 0);
        chki("t5_in_ready", int'(in_ready_a), 1);
        repeat (40) drive_a(1'b0, '0, 1'b1, acc, e);
        chki("t5_no_done_after_reset", done_cyc_a.size(), 0);
        chki("t5_out_valid_idle", int'(out_valid_a), 0);
    endtask

    task automatic run_b();
        for (int i = 0; i < 10000; i++) begin
            drive_b(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20; i++) drive_b(1'b0, '0, 1'b1);
        chki("t6_scoreboard_empty", exp_b.size(), 0);
        chki("t6_fifo_count_zero", int'(fifo_count_b), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete, %0d vectors so far", n_cmp);
        $fatal(1);
    end

    initial begin
        reset_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        reset_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        chk("rst_core_in", core_in_a, '0);
        chki("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_data", out_data_a, '0);
        chki("rst_done", int'(done_a), 0);
        chki("rst_inflight", int'(inflight_a), 0);
        chki("rst_fifo_count", int'(fifo_count_a), 0);
        chki("rst_in_ready", int'(in_ready_a), 1);
        chki("rst_in_ready_b", int'(in_ready_b), 1);
        fork
            run_a();
            run_b();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
